// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared FSM state, opcode, funct, ALU-control and mux-select encodings for the multicycle controller, ALU and benches
package mc_controller_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
endpackage

// File: rtl/mc_controller_alu_dec.sv
// alu_dec: R-type funct to ALU control decode; ports: funct in, alucont out (ADD on unknown), valid out
module alu_dec
  import mc_controller_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucont,
  output logic       valid
);
  assign alucont = funct == FN_ADD ? ALU_ADD :
                   funct == FN_SUB ? ALU_SUB :
                   funct == FN_AND ? ALU_AND :
                   funct == FN_OR  ? ALU_OR  :
                   funct == FN_SLT ? ALU_SLT : ALU_ADD;
  assign valid = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle Moore control FSM; ports: clk_i, rst_i, op_i, funct_i, zero_i in; datapath enables, mux selects, alucont_o, pcen_o, illegal_o out
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter bit ADDI_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic       pcwrite_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       regwrite_o,
  output logic       alusrca_o,
  output logic       branch_o,
  output logic       iord_o,
  output logic       memtoreg_o,
  output logic       regdst_o,
  output logic       pcen_o,
  output logic       illegal_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] pcsrc_o,
  output logic [2:0] alucont_o
);
  state_t state, next, cur;
  logic [2:0] dec_alucont;
  logic dec_valid;
  alu_dec u_alu_dec (.funct(funct_i), .alucont(dec_alucont), .valid(dec_valid));
  always_ff @(posedge clk_i)
    state <= rst_i ? S_FETCH : next;
  // While reset is held the outputs are decoded as FETCH, with the write enables masked below.
  always_comb begin
    cur = rst_i ? S_FETCH : state;
    next = S_FETCH;
    {pcwrite_o, memwrite_o, irwrite_o, regwrite_o, alusrca_o, branch_o} = '0;
    {iord_o, memtoreg_o, regdst_o, illegal_o} = '0;
    alusrcb_o = SRCB_REG;
    pcsrc_o = PC_ALU;
    alucont_o = ALU_ADD;
    case (cur)
      S_FETCH: begin
        irwrite_o = 1'b1;
        pcwrite_o = 1'b1;
        alusrcb_o = SRCB_4;
        next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb_o = SRCB_IMMSH;
        next = op_i == OP_LW || op_i == OP_SW ? S_MEMADR :
               op_i == OP_RTYPE ? S_EXECUTE :
               op_i == OP_BEQ ? S_BRANCH :
               op_i == OP_ADDI && ADDI_EN ? S_ADDIEXEC :
               op_i == OP_J ? S_JUMP : S_FETCH;
        illegal_o = next == S_FETCH;
      end
      S_MEMADR, S_ADDIEXEC: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
        next = cur == S_ADDIEXEC ? S_ADDIWB : op_i == OP_SW ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_o = 1'b1;
        next = S_MEMWB;
      end
      S_MEMWR: begin
        iord_o = 1'b1;
        memwrite_o = 1'b1;
      end
      S_MEMWB: begin
        regwrite_o = 1'b1;
        memtoreg_o = 1'b1;
      end
      S_EXECUTE: begin
        alusrca_o = 1'b1;
        alucont_o = dec_alucont;
        illegal_o = !dec_valid;
        next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_o = 1'b1;
        regdst_o = 1'b1;
      end
      S_ADDIWB: regwrite_o = 1'b1;
      S_BRANCH: begin
        alusrca_o = 1'b1;
        alucont_o = ALU_SUB;
        branch_o = 1'b1;
        pcsrc_o = PC_ALUOUT;
      end
      S_JUMP: begin
        pcwrite_o = 1'b1;
        pcsrc_o = PC_JUMP;
      end
      default: next = S_FETCH;
    endcase
    if (rst_i) {pcwrite_o, irwrite_o} = '0;
    pcen_o = pcwrite_o | (branch_o & zero_i);
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed self-checking bench for mc_controller (ADDI_EN=1 and ADDI_EN=0 instances)
module tb_mc_controller;
  import mc_controller_pkg::*;
  // Vector order: pcwrite memwrite irwrite regwrite alusrca branch iord memtoreg regdst pcen illegal | alusrcb | pcsrc | alucont
  localparam logic [17:0] V_RST    = 18'b0_0_0_0_0_0_0_0_0_0_0_01_00_010;
  localparam logic [17:0] V_FETCH  = 18'b1_0_1_0_0_0_0_0_0_1_0_01_00_010;
  localparam logic [17:0] V_DECODE = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_010;
  localparam logic [17:0] V_MEMADR = 18'b0_0_0_0_1_0_0_0_0_0_0_10_00_010;
  localparam logic [17:0] V_MEMRD  = 18'b0_0_0_0_0_0_1_0_0_0_0_00_00_010;
  localparam logic [17:0] V_MEMWR  = 18'b0_1_0_0_0_0_1_0_0_0_0_00_00_010;
  localparam logic [17:0] V_MEMWB  = 18'b0_0_0_1_0_0_0_1_0_0_0_00_00_010;
  localparam logic [17:0] V_EXEC0  = 18'b0_0_0_0_1_0_0_0_0_0_0_00_00_000;
  localparam logic [17:0] V_ALUWB  = 18'b0_0_0_1_0_0_0_0_1_0_0_00_00_010;
  localparam logic [17:0] V_ADDIWB = 18'b0_0_0_1_0_0_0_0_0_0_0_00_00_010;
  localparam logic [17:0] V_BRZ0   = 18'b0_0_0_0_1_1_0_0_0_0_0_00_01_110;
  localparam logic [17:0] V_BRZ1   = 18'b0_0_0_0_1_1_0_0_0_1_0_00_01_110;
  localparam logic [17:0] V_JUMP   = 18'b1_0_0_0_0_0_0_0_0_1_0_00_10_010;
  localparam logic [17:0] V_ILL    = 18'h00080;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0;
  logic [5:0] op = 6'b0, funct = 6'b0;
  logic pcw0, mw0, irw0, rw0, sa0, br0, iord0, m2r0, rd0, pcen0, ill0;
  logic pcw1, mw1, irw1, rw1, sa1, br1, iord1, m2r1, rd1, pcen1, ill1;
  logic [1:0] sb0, ps0, sb1, ps1;
  logic [2:0] ac0, ac1;
  logic [17:0] v0, v1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mc_controller #(.ADDI_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct_i(funct), .zero_i(zero),
    .pcwrite_o(pcw0), .memwrite_o(mw0), .irwrite_o(irw0), .regwrite_o(rw0),
    .alusrca_o(sa0), .branch_o(br0), .iord_o(iord0), .memtoreg_o(m2r0),
    .regdst_o(rd0), .pcen_o(pcen0), .illegal_o(ill0), .alusrcb_o(sb0),
    .pcsrc_o(ps0), .alucont_o(ac0));
  mc_controller #(.ADDI_EN(1'b0)) dut_noaddi (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct_i(funct), .zero_i(zero),
    .pcwrite_o(pcw1), .memwrite_o(mw1), .irwrite_o(irw1), .regwrite_o(rw1),
    .alusrca_o(sa1), .branch_o(br1), .iord_o(iord1), .memtoreg_o(m2r1),
    .regdst_o(rd1), .pcen_o(pcen1), .illegal_o(ill1), .alusrcb_o(sb1),
    .pcsrc_o(ps1), .alucont_o(ac1));
  assign v0 = {pcw0, mw0, irw0, rw0, sa0, br0, iord0, m2r0, rd0, pcen0, ill0, sb0, ps0, ac0};
  assign v1 = {pcw1, mw1, irw1, rw1, sa1, br1, iord1, m2r1, rd1, pcen1, ill1, sb1, ps1, ac1};
  task automatic start(input logic [5:0] o, input logic [5:0] f, input logic z);
    @(posedge clk); #1;
    rst = 1'b1;
    op = o;
    funct = f;
    zero = z;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (v0 !== V_RST) begin errors++; $display("FAIL reset cyc%0d got %b exp %b", i, v0, V_RST); end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (v0 !== V_FETCH) begin errors++; $display("FAIL reset_release got %b exp %b", v0, V_FETCH); end
  endtask
  task automatic test_lw();
    logic [17:0] e [6];
    e = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH};
    start(OP_LW, 6'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (v0 !== e[i]) begin errors++; $display("FAIL lw cyc%0d got %b exp %b", i, v0, e[i]); end
    end
  endtask
  task automatic test_rtype();
    logic [5:0] fn [6];
    logic [2:0] ac [6];
    logic [17:0] e [5];
    fn = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'b111111};
    ac = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    for (int k = 0; k < 6; k++) begin
      e = '{V_FETCH, V_DECODE, V_EXEC0 | {15'b0, ac[k]} | (k == 5 ? V_ILL : 18'b0), V_ALUWB, V_FETCH};
      start(OP_RTYPE, fn[k], 1'b0);
      for (int i = 0; i < 5; i++) begin
        if (i > 0) begin @(posedge clk); #1; end
        checks++;
        if (v0 !== e[i]) begin errors++; $display("FAIL rtype funct=%b cyc%0d got %b exp %b", fn[k], i, v0, e[i]); end
      end
    end
  endtask
  task automatic test_beq();
    logic [17:0] e [4];
    for (int z = 1; z >= 0; z--) begin
      e = '{V_FETCH, V_DECODE, z == 1 ? V_BRZ1 : V_BRZ0, V_FETCH};
      start(OP_BEQ, 6'b0, z[0]);
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin @(posedge clk); #1; end
        checks++;
        if (v0 !== e[i]) begin errors++; $display("FAIL beq z=%0d cyc%0d got %b exp %b", z, i, v0, e[i]); end
      end
    end
  endtask
  task automatic test_jump();
    logic [17:0] e [4];
    e = '{V_FETCH, V_DECODE, V_JUMP, V_FETCH};
    start(OP_J, 6'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (v0 !== e[i]) begin errors++; $display("FAIL jump cyc%0d got %b exp %b", i, v0, e[i]); end
    end
  endtask
  task automatic test_illegal();
    logic [17:0] e [3];
    e = '{V_FETCH, V_DECODE | V_ILL, V_FETCH};
    start(6'b111111, 6'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (v0 !== e[i]) begin errors++; $display("FAIL illegal cyc%0d got %b exp %b", i, v0, e[i]); end
    end
  endtask
  task automatic test_sw_reset();
    logic [17:0] e [4];
    e = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
    start(OP_SW, 6'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (v0 !== e[i]) begin errors++; $display("FAIL sw cyc%0d got %b exp %b", i, v0, e[i]); end
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (v0 !== V_RST) begin errors++; $display("FAIL sw_rst_hold cyc%0d got %b exp %b", i, v0, V_RST); end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (v0 !== V_FETCH) begin errors++; $display("FAIL sw_rst_release got %b exp %b", v0, V_FETCH); end
    @(posedge clk); #1;
    checks++;
    if (v0 !== V_DECODE) begin errors++; $display("FAIL sw_rst_decode got %b exp %b", v0, V_DECODE); end
  endtask
  task automatic test_addi();
    logic [17:0] e0 [5];
    logic [17:0] e1 [5];
    e0 = '{V_FETCH, V_DECODE, V_MEMADR, V_ADDIWB, V_FETCH};
    e1 = '{V_FETCH, V_DECODE | V_ILL, V_FETCH, V_DECODE | V_ILL, V_FETCH};
    start(OP_ADDI, 6'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (v0 !== e0[i]) begin errors++; $display("FAIL addi_en1 cyc%0d got %b exp %b", i, v0, e0[i]); end
      checks++;
      if (v1 !== e1[i]) begin errors++; $display("FAIL addi_en0 cyc%0d got %b exp %b", i, v1, e1[i]); end
    end
  endtask
  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_jump();
    test_illegal();
    test_sw_reset();
    test_addi();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
